// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor built around one full-adder cell
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   start_valid  a, b and sub are valid for acceptance
//   start_ready  block is idle and can accept an operation
//   a, b         WIDTH-bit operands
//   sub          0: a+b, 1: a-b
//   result       WIDTH-bit sum or difference
//   carry_out    carry out of the MSB (for sub, 1 means no borrow)
//   overflow     signed two's-complement overflow
//   zero         result equals 0
//   done_valid   result and flags are valid
//   done_ready   consumer accepts the result

module serial_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    count;

    logic             sum_bit;
    logic             carry_bit;
    logic [WIDTH-1:0] result_next;
    logic             last_bit;

    // Single full-adder cell working on the current LSBs.
    assign sum_bit     = op_a[0] ^ op_b[0] ^ carry;
    assign carry_bit   = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    assign result_next = {sum_bit, result[WIDTH-1:1]};
    assign last_bit    = (count == LAST);

    assign start_ready = (state == IDLE);
    assign done_valid  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_valid) state_next = RUN;
            RUN:  if (last_bit)    state_next = DONE;
            DONE: if (done_ready)  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            count     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        // Subtraction is a + ~b + 1: invert b, seed the carry with 1.
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        count <= '0;
                    end
                end
                RUN: begin
                    result <= result_next;
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= carry_bit;
                    count  <= count + 1'b1;
                    if (last_bit) begin
                        carry_out <= carry_bit;
                        // Carry into the MSB differs from carry out of it on signed overflow.
                        overflow  <= carry_bit ^ carry;
                        zero      <= (result_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - table-driven self-checking bench for serial_addsub

module tb_serial_addsub;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         done_valid;
    logic         done_ready;

    int checks;
    int failures;

    serial_addsub #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .sub         (sub),
        .result      (result),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .zero        (zero),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic scramble();
        start_valid = 1'($urandom);
        a           = $urandom;
        b           = $urandom;
        sub         = 1'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one operation from IDLE. Inputs are scrambled every cycle after
    // acceptance; hold>0 keeps done_ready low for that many DONE cycles.
    task automatic do_op(input vec_t v, input int hold, input string tag);
        int cycles;
        start_valid = 1'b1;
        a           = v.a;
        b           = v.b;
        sub         = v.sub;
        done_ready  = (hold == 0);
        step();
        chk({tag, " start_ready_low"}, W'(start_ready), W'(0));
        cycles = 0;
        while (!done_valid && cycles < 100) begin
            scramble();
            step();
            cycles++;
        end
        start_valid = 1'b0;
        chk({tag, " latency"}, W'(cycles), W'(W));
        chk({tag, " result"}, result, v.res);
        chk({tag, " carry_out"}, W'(carry_out), W'(v.co));
        chk({tag, " overflow"}, W'(overflow), W'(v.ov));
        chk({tag, " zero"}, W'(zero), W'(v.z));
        for (int i = 0; i < hold; i++) begin
            scramble();
            step();
            chk({tag, " hold_done_valid"}, W'(done_valid), W'(1));
            chk({tag, " hold_start_ready"}, W'(start_ready), W'(0));
            chk({tag, " hold_result"}, result, v.res);
            chk({tag, " hold_flags"}, W'({carry_out, overflow, zero}), W'({v.co, v.ov, v.z}));
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        step();
        chk({tag, " idle_start_ready"}, W'(start_ready), W'(1));
        chk({tag, " idle_done_valid"}, W'(done_valid), W'(0));
    endtask

    initial begin
        vec_t v;
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        start_valid = 1'b1;
        a           = 32'd7;
        b           = 32'd9;
        sub         = 1'b0;
        done_ready  = 1'b1;

        //           a             b             sub   result        co    ov    z
        vecs[0]  = '{32'd5,        32'd3,        1'b0, 32'd8,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'd3,        32'd5,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h1234ABCD, 32'h1234ABCD, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'd100,      32'd23,       1'b0, 32'd123,      1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};

        // Reset with start_valid high: must not start an operation.
        step();
        step();
        rst = 1'b0;
        start_valid = 1'b0;
        chk("reset start_ready", W'(start_ready), W'(1));
        chk("reset done_valid", W'(done_valid), W'(0));
        chk("reset result", result, W'(0));
        chk("reset flags", W'({carry_out, overflow, zero}), W'(0));
        step();
        chk("post_reset idle", W'(start_ready), W'(1));

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE for 10 cycles while inputs toggle.
        do_op(vecs[0], 10, "backpressure");

        // Abort in the middle of RUN when count has reached 10.
        start_valid = 1'b1;
        a           = 32'hFFFFFFFF;
        b           = 32'h00000001;
        sub         = 1'b0;
        done_ready  = 1'b1;
        step();
        start_valid = 1'b0;
        repeat (10) step();
        chk("abort still running", W'(done_valid), W'(0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort start_ready", W'(start_ready), W'(1));
        chk("abort done_valid", W'(done_valid), W'(0));
        chk("abort result", result, W'(0));
        v = vecs[9];
        do_op(v, 0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
